// File: rtl/popcount_result_reader.sv
// Bus-initiating reader that scans the popcount result words, sums the legal counts,
// tracks the first maximum and flags the first word whose value exceeds 32.
module popcount_result_reader #(
    parameter int unsigned BASE_IDX = 20,
    parameter int unsigned COUNT    = 20,
    parameter int unsigned IDX_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [31:0]      DataAdr,
    input  logic [31:0]      ReadData,
    output logic             busy,
    output logic             done,
    output logic [31:0]      Total,
    output logic [5:0]       MaxCount,
    output logic [IDX_W-1:0] MaxIdx,
    output logic             Error,
    output logic [IDX_W-1:0] ErrIdx
);

    localparam int unsigned    ADR_W     = 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);
    localparam logic [ADR_W-1:0] BASE_ADR = ADR_W'(BASE_IDX) << 2;
    localparam logic [31:0]    MAX_LEGAL = 32'd32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [31:0]      adr_n;
    logic [31:0]      total_n;
    logic [5:0]       max_n;
    logic [IDX_W-1:0] max_idx_n;
    logic             err_n;
    logic [IDX_W-1:0] err_idx_n;
    logic             busy_n;
    logic             done_n;
    logic             legal;

    assign legal = (ReadData <= MAX_LEGAL);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            DataAdr  <= '0;
            Total    <= '0;
            MaxCount <= '0;
            MaxIdx   <= '0;
            Error    <= 1'b0;
            ErrIdx   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            DataAdr  <= adr_n;
            Total    <= total_n;
            MaxCount <= max_n;
            MaxIdx   <= max_idx_n;
            Error    <= err_n;
            ErrIdx   <= err_idx_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        adr_n     = DataAdr;
        total_n   = Total;
        max_n     = MaxCount;
        max_idx_n = MaxIdx;
        err_n     = Error;
        err_idx_n = ErrIdx;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n   = SCAN;
                    idx_n     = '0;
                    adr_n     = BASE_ADR;
                    total_n   = '0;
                    max_n     = '0;
                    max_idx_n = '0;
                    err_n     = 1'b0;
                    err_idx_n = '0;
                end
            end
            SCAN: begin
                if (legal) begin
                    total_n = Total + ReadData;
                    // Strict compare keeps the first occurrence on ties
                    if (ReadData > 32'(MaxCount)) begin
                        max_n     = ReadData[5:0];
                        max_idx_n = idx;
                    end
                end else if (!Error) begin
                    err_n     = 1'b1;
                    err_idx_n = idx;
                end
                if (idx == LAST_IDX) begin
                    state_n = DONE;
                end else begin
                    idx_n = idx + IDX_W'(1);
                    adr_n = (ADR_W'(BASE_IDX) + ADR_W'(idx) + 32'd1) << 2;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n == SCAN);
        done_n = (state_n == DONE);
    end

endmodule

// File: tb/tb_popcount_result_reader.sv
// Randomized and directed bench for popcount_result_reader against a loop-based model.
module tb_popcount_result_reader;

    localparam int unsigned BASE_IDX = 20;
    localparam int unsigned COUNT    = 20;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned MEM_W    = 64;

    logic             clk;
    logic             reset;
    logic             start;
    logic [31:0]      DataAdr;
    logic [31:0]      ReadData;
    logic             busy;
    logic             done;
    logic [31:0]      Total;
    logic [5:0]       MaxCount;
    logic [IDX_W-1:0] MaxIdx;
    logic             Error;
    logic [IDX_W-1:0] ErrIdx;

    logic [31:0] mem [MEM_W];

    int n_checks = 0;
    int n_pass   = 0;

    popcount_result_reader #(
        .BASE_IDX(BASE_IDX),
        .COUNT(COUNT),
        .IDX_W(IDX_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .DataAdr(DataAdr),
        .ReadData(ReadData),
        .busy(busy),
        .done(done),
        .Total(Total),
        .MaxCount(MaxCount),
        .MaxIdx(MaxIdx),
        .Error(Error),
        .ErrIdx(ErrIdx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational memory read port
    always_comb begin
        if ((DataAdr >> 2) < 32'(MEM_W)) ReadData = mem[DataAdr[7:2]];
        else                             ReadData = 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Reference: sum legal words, first maximum, first illegal word
    task automatic model(output logic [31:0] tot, output logic [31:0] mx,
                         output logic [31:0] mx_i, output logic [31:0] er,
                         output logic [31:0] er_i);
        tot = 0; mx = 0; mx_i = 0; er = 0; er_i = 0;
        for (int k = 0; k < int'(COUNT); k++) begin
            logic [31:0] v;
            v = mem[BASE_IDX + k];
            if (v > 32) begin
                if (er == 0) begin er = 1; er_i = 32'(k); end
            end else begin
                tot += v;
                if (v > mx) begin mx = v; mx_i = 32'(k); end
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_adr"}, DataAdr, 32'd0);
        check({tag, "_flags"}, {28'd0, busy, done, Error, 1'b0}, 32'd0);
        check({tag, "_res"}, Total | 32'(MaxCount) | 32'(MaxIdx) | 32'(ErrIdx), 32'd0);
    endtask

    // Run a scan from start pulse to done, checking address stepping and results
    task automatic run_scan(input string tag);
        logic [31:0] tot, mx, mx_i, er, er_i;
        int k;
        bit adr_ok;
        bit got_done;
        model(tot, mx, mx_i, er, er_i);
        pulse_start();
        k = 0; adr_ok = 1; got_done = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (busy) begin
                if (DataAdr != 32'((BASE_IDX + k) << 2)) adr_ok = 0;
                k++;
            end else if (done) begin
                got_done = 1;
                break;
            end
        end
        check({tag, "_done"}, 32'(got_done), 32'd1);
        check({tag, "_busy_cycles"}, 32'(k), 32'(COUNT));
        check({tag, "_adr_seq"}, 32'(adr_ok), 32'd1);
        check({tag, "_total"}, Total, tot);
        check({tag, "_max"}, 32'(MaxCount), mx);
        check({tag, "_maxidx"}, 32'(MaxIdx), mx_i);
        check({tag, "_err"}, 32'(Error), er);
        if (er != 0) check({tag, "_erridx"}, 32'(ErrIdx), er_i);
    endtask

    initial begin
        for (int i = 0; i < int'(MEM_W); i++) mem[i] = 32'(i * 7 + 3);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_outputs_zero("reset_idle");
        end

        // Ascending counts
        for (int k = 0; k < int'(COUNT); k++) mem[BASE_IDX + k] = 32'(k);
        run_scan("ramp");
        check("ramp_total_const", Total, 32'd190);

        // All maximum legal value: tie keeps offset 0
        for (int k = 0; k < int'(COUNT); k++) mem[BASE_IDX + k] = 32'd32;
        run_scan("all32");
        check("all32_maxidx_const", 32'(MaxIdx), 32'd0);

        // Illegal words at offsets 5 and 10
        for (int k = 0; k < int'(COUNT); k++) mem[BASE_IDX + k] = 32'd1;
        mem[25] = 32'd33;
        mem[30] = 32'hFFFF_FFFF;
        run_scan("illegal");
        check("illegal_erridx_const", 32'(ErrIdx), 32'd5);
        check("illegal_total_const", Total, 32'd18);

        // Re-pulse start mid-scan, then reset at offset 7
        for (int k = 0; k < int'(COUNT); k++) mem[BASE_IDX + k] = 32'(k % 9);
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("midscan_adr", DataAdr, 32'((BASE_IDX + k) << 2));
            if (k == 3) start = 1'b1;
            if (k == 4) start = 1'b0;
            if (k == 7) reset = 1'b1;
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("midscan_reset");
        run_scan("after_reset");

        // Restart from DONE
        for (int k = 0; k < int'(COUNT); k++) mem[BASE_IDX + k] = 32'd0;
        mem[20] = 32'd5;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("restart_done_drop", {30'd0, busy, done}, 32'd2);
        for (int c = 0; c < 100 && !done; c++) @(negedge clk);
        check("restart_total", Total, 32'd5);
        check("restart_max", 32'(MaxCount), 32'd5);
        check("restart_maxidx", 32'(MaxIdx), 32'd0);

        // Randomized result regions, occasionally with illegal words
        for (int t = 0; t < 12; t++) begin
            for (int k = 0; k < int'(COUNT); k++) begin
                if ($urandom_range(0, 15) == 0) mem[BASE_IDX + k] = 32'd33 + $urandom_range(0, 1000);
                else if ($urandom_range(0, 31) == 0) mem[BASE_IDX + k] = $urandom | 32'h8000_0000;
                else mem[BASE_IDX + k] = 32'($urandom_range(0, 32));
            end
            run_scan($sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
